instruction_loader: RTL and testbench



---
 rtl/instruction_loader_pkg.sv | 15 +
 rtl/instruction_loader.sv | 95 +++++++++
 tb/tb_instruction_loader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_loader_pkg.sv
// instruction_loader_pkg: state encoding, default widths and byte-order constants for instruction_loader
package instruction_loader_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int WORD_W = 16;
    localparam bit BYTE_ORDER_BIG = 1'b1;
    localparam bit BYTE_ORDER_LITTLE = 1'b0;
    typedef enum logic [2:0] {
        IDLE,
        RECV_HI,
        RECV_LO,
        WRITE,
        DONE,
        RECV_SUM
    } state_t;
endpackage

// File: rtl/instruction_loader.sv
// instruction_loader: byte-stream to 16-bit instruction memory writer; INSTRUCTION_LOADER_CHECKSUM_EN adds a trailing checksum byte
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter bit BIG_ENDIAN = BYTE_ORDER_BIG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] baseAddress,
    input  logic [ADDR_W:0]   wordCount,
    input  logic [7:0]        byteData,
    input  logic              byteValid,
    output logic              byteReady,
    output logic              memWriteEn,
    output logic [ADDR_W-1:0] memAddress,
    output logic [WORD_W-1:0] memData,
    output logic              busy,
    output logic              done,
    output logic              checksumError
);
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    localparam state_t LAST = RECV_SUM;
`else
    localparam state_t LAST = DONE;
`endif
    state_t state, nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0] cnt;
    logic [7:0] hold;
    logic hs, accept;
    logic [WORD_W-1:0] word;
    assign hs = byteValid && byteReady;
    assign accept = start && state == IDLE;
    assign word = BIG_ENDIAN ? {hold, byteData} : {byteData, hold};
    always_comb begin
        nxt = state == IDLE ? (start ? (wordCount == '0 ? LAST : RECV_HI) : IDLE) :
              state == RECV_HI ? (hs ? RECV_LO : RECV_HI) :
              state == RECV_LO ? (hs ? WRITE : RECV_LO) :
              state == WRITE ? (cnt == (ADDR_W+1)'(1) ? LAST : RECV_HI) :
              state == RECV_SUM ? (hs ? DONE : RECV_SUM) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            byteReady <= 1'b0;
            memWriteEn <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            memAddress <= '0;
            memData <= '0;
            addr <= '0;
            cnt <= '0;
            hold <= '0;
        end else begin
            state <= nxt;
            byteReady <= nxt == RECV_HI || nxt == RECV_LO || nxt == RECV_SUM;
            busy <= nxt != IDLE;
            done <= nxt == DONE;
            memWriteEn <= nxt == WRITE;
            if (accept) begin
                addr <= baseAddress;
                cnt <= wordCount;
            end
            if (hs && state == RECV_HI) hold <= byteData;
            if (hs && state == RECV_LO) begin
                memAddress <= addr;
                memData <= word;
            end
            if (state == WRITE) begin
                addr <= addr + 1'b1;
                cnt <= cnt - 1'b1;
            end
        end
    end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic [7:0] sum, total;
    assign total = sum + byteData;
    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= '0;
            checksumError <= 1'b0;
        end else begin
            if (accept) begin
                sum <= '0;
                checksumError <= 1'b0;
            end else if (hs && state == RECV_SUM) checksumError <= total != 8'd0;
            else if (hs) sum <= total;
        end
    end
`else
    assign checksumError = 1'b0;
`endif
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: directed self-checking bench for instruction_loader (big- and little-endian instances)
module tb_instruction_loader;
    logic clk = 1'b0;
    logic reset, start, byteValid;
    logic [7:0] baseAddress, byteData;
    logic [8:0] wordCount;
    logic byteReady, memWriteEn, busy, done, checksumError;
    logic [7:0] memAddress;
    logic [15:0] memData;
    logic le_byteReady, le_memWriteEn, le_busy, le_done, le_checksumError;
    logic [7:0] le_memAddress;
    logic [15:0] le_memData;
    int checks = 0, failures = 0, ndone = 0, rdy_viol = 0, done_base;
    logic [23:0] wq[$];
    logic [7:0] last_sum;

    always #5 clk = ~clk;

    instruction_loader #(.ADDR_W(8), .BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .baseAddress(baseAddress),
        .wordCount(wordCount), .byteData(byteData), .byteValid(byteValid),
        .byteReady(byteReady), .memWriteEn(memWriteEn), .memAddress(memAddress),
        .memData(memData), .busy(busy), .done(done), .checksumError(checksumError)
    );

    instruction_loader #(.ADDR_W(8), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .reset(reset), .start(start), .baseAddress(baseAddress),
        .wordCount(wordCount), .byteData(byteData), .byteValid(byteValid),
        .byteReady(le_byteReady), .memWriteEn(le_memWriteEn), .memAddress(le_memAddress),
        .memData(le_memData), .busy(le_busy), .done(le_done), .checksumError(le_checksumError)
    );

    always @(negedge clk) begin
        if (memWriteEn) begin
            wq.push_back({memAddress, memData});
            if (byteReady) rdy_viol++;
        end
        if (done) ndone++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input logic [7:0] b, input logic [8:0] n);
        start = 1'b1;
        baseAddress = b;
        wordCount = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] v, input bit gap);
        int k = 0;
        if (gap) begin
            byteValid = 1'b0;
            @(negedge clk);
        end
        byteData = v;
        byteValid = 1'b1;
        while (!byteReady && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("send_ready", 32'(byteReady), 32'd1);
        @(negedge clk);
        byteValid = 1'b0;
    endtask

    task automatic send_sum(input logic [7:0] v);
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        send(v, 1'b0);
`else
        last_sum = v;
`endif
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        byteValid = 1'b0;
        byteData = '0;
        baseAddress = '0;
        wordCount = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(byteReady), 32'd0);
        chk("rst_we", 32'(memWriteEn), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cerr", 32'(checksumError), 32'd0);
        chk("rst_addr", 32'(memAddress), 32'd0);
        chk("rst_data", 32'(memData), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // basic load, valid held
        done_base = ndone;
        start_load(8'h10, 9'd2);
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_ready", 32'(byteReady), 32'd1);
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        send(8'hAB, 1'b0);
        send(8'hCD, 1'b0);
        send_sum(8'h42);
        wait_done();
        chk("basic_busy_at_done", 32'(busy), 32'd1);
        @(negedge clk);
        chk("basic_busy_after", 32'(busy), 32'd0);
        chk("basic_done_after", 32'(done), 32'd0);
        chk("basic_nwr", wq.size(), 32'd2);
        if (wq.size() == 2) begin
            chk("basic_w0", 32'(wq[0]), 32'h101234);
            chk("basic_w1", 32'(wq[1]), 32'h11ABCD);
        end
        chk("basic_ndone", ndone - done_base, 32'd1);
        chk("basic_le_data", 32'(le_memData), 32'hCDAB);
        chk("hold_data", 32'(memData), 32'hABCD);
        chk("hold_addr", 32'(memAddress), 32'h11);
        wq.delete();

        // gaps in byteValid, then a start during DONE must be ignored
        start_load(8'h10, 9'd2);
        send(8'h12, 1'b1);
        send(8'h34, 1'b1);
        send(8'hAB, 1'b1);
        send(8'hCD, 1'b1);
        send_sum(8'h42);
        wait_done();
        start_load(8'h77, 9'd1);
        chk("done_start_busy", 32'(busy), 32'd0);
        chk("gap_nwr", wq.size(), 32'd2);
        if (wq.size() == 2) begin
            chk("gap_w0", 32'(wq[0]), 32'h101234);
            chk("gap_w1", 32'(wq[1]), 32'h11ABCD);
        end
        wq.delete();

        // address wrap
        start_load(8'hFF, 9'd2);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        send_sum(8'hF6);
        wait_done();
        @(negedge clk);
        chk("wrap_nwr", wq.size(), 32'd2);
        if (wq.size() == 2) begin
            chk("wrap_w0", 32'(wq[0]), 32'hFF0102);
            chk("wrap_w1", 32'(wq[1]), 32'h000304);
        end
        wq.delete();

        // zero-word load
        start_load(8'h50, 9'd0);
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        chk("zero_sum_ready", 32'(byteReady), 32'd1);
        send(8'h00, 1'b0);
        wait_done();
        chk("zero_cerr", 32'(checksumError), 32'd0);
`else
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd1);
`endif
        @(negedge clk);
        chk("zero_idle", 32'(busy), 32'd0);
        chk("zero_nwr", wq.size(), 32'd0);

        // reset mid-word
        start_load(8'h30, 9'd2);
        send(8'h55, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(byteReady), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_we", 32'(memWriteEn), 32'd0);
        chk("mid_rst_addr", 32'(memAddress), 32'd0);
        chk("mid_rst_data", 32'(memData), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_nwr", wq.size(), 32'd0);
        start_load(8'h20, 9'd1);
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        send_sum(8'hBA);
        wait_done();
        @(negedge clk);
        chk("after_rst_nwr", wq.size(), 32'd1);
        if (wq.size() == 1) chk("after_rst_w0", 32'(wq[0]), 32'h201234);
        chk("le_data", 32'(le_memData), 32'h3412);
        wq.delete();

        // start while busy is ignored
        start_load(8'h40, 9'd2);
        send(8'h11, 1'b0);
        start_load(8'h80, 9'd1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        send_sum(8'h56);
        wait_done();
        @(negedge clk);
        chk("busy_start_nwr", wq.size(), 32'd2);
        if (wq.size() == 2) begin
            chk("busy_start_w0", 32'(wq[0]), 32'h401122);
            chk("busy_start_w1", 32'(wq[1]), 32'h413344);
        end
        wq.delete();

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        start_load(8'h00, 9'd1);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'hFD, 1'b0);
        wait_done();
        chk("sum_good", 32'(checksumError), 32'd0);
        @(negedge clk);
        start_load(8'h01, 9'd1);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        wait_done();
        chk("sum_bad", 32'(checksumError), 32'd1);
        @(negedge clk);
        chk("sum_bad_hold", 32'(checksumError), 32'd1);
        start_load(8'h02, 9'd1);
        chk("sum_clear", 32'(checksumError), 32'd0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'hFD, 1'b0);
        wait_done();
        @(negedge clk);
        wq.delete();
`else
        chk("cerr_tied", 32'(checksumError), 32'd0);
`endif
        chk("ready_in_write", rdy_viol, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
